// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port synchronous memory between NUM_PORTS requesters.
// Arbitration is round-robin by default; define MEMORY_ARB_FIXED_PRIORITY_EN for fixed
// priority, where the lowest-index requester always wins.
module memory_arbiter #(
    parameter int NUM_PORTS        = 2,
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int MEM_LAT          = 1
) (
    input  logic                                  clock_i,
    input  logic                                  reset_i,
    input  logic [NUM_PORTS-1:0]                  req_i,
    input  logic [4*NUM_PORTS-1:0]                wb_i,
    input  logic [MEMORY_BUS_WIDTH*NUM_PORTS-1:0] addr_i,
    input  logic [MEMORY_BUS_WIDTH*NUM_PORTS-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]                  gnt_o,
    output logic [NUM_PORTS-1:0]                  rvalid_o,
    output logic [MEMORY_BUS_WIDTH-1:0]           rdata_o,
    output logic [MEMORY_BUS_WIDTH-1:0]           mem_addr_in_o,
    output logic [MEMORY_BUS_WIDTH-1:0]           mem_data_in_o,
    output logic [3:0]                            mem_wb_in_o,
    input  logic [MEMORY_BUS_WIDTH-1:0]           mem_data_out_i
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    state_t                      state_q;
    logic [PW-1:0]               sel_q;
    logic [PW-1:0]               win_d;
    logic [2:0]                  cnt_q;
    logic [NUM_PORTS-1:0]        gnt_q;
    logic [NUM_PORTS-1:0]        rvalid_q;
    logic [MEMORY_BUS_WIDTH-1:0] rdata_q;
    logic [MEMORY_BUS_WIDTH-1:0] addr_q;
    logic [MEMORY_BUS_WIDTH-1:0] data_q;
    logic [3:0]                  wb_q;
`ifndef MEMORY_ARB_FIXED_PRIORITY_EN
    logic [PW-1:0]               ptr_q;
`endif

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NUM_PORTS);
    endfunction

    // Winner search: iterate from the farthest candidate down so the closest requester wins.
    always_comb begin
        win_d = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
`ifdef MEMORY_ARB_FIXED_PRIORITY_EN
            if (req_i[PW'(i)]) win_d = PW'(i);
`else
            if (req_i[wrap(int'(ptr_q) + i)]) win_d = wrap(int'(ptr_q) + i);
`endif
    end

    // Transaction FSM: IDLE samples requests, ACCESS drives the memory, WAIT covers read latency.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wb_q     <= '0;
`ifndef MEMORY_ARB_FIXED_PRIORITY_EN
            ptr_q    <= '0;
`endif
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                IDLE: if (|req_i) begin
                    addr_q  <= addr_i[int'(win_d)*MEMORY_BUS_WIDTH +: MEMORY_BUS_WIDTH];
                    data_q  <= wdata_i[int'(win_d)*MEMORY_BUS_WIDTH +: MEMORY_BUS_WIDTH];
                    wb_q    <= wb_i[int'(win_d)*4 +: 4];
                    gnt_q   <= ONE << win_d;
                    sel_q   <= win_d;
                    state_q <= ACCESS;
`ifndef MEMORY_ARB_FIXED_PRIORITY_EN
                    ptr_q   <= wrap(int'(win_d) + 1);
`endif
                end
                ACCESS: begin
                    wb_q    <= '0;
                    cnt_q   <= 3'(MEM_LAT - 1);
                    state_q <= (wb_q != '0) ? IDLE : WAIT;
                end
                WAIT: if (cnt_q == '0) begin
                    rdata_q  <= mem_data_out_i;
                    rvalid_q <= ONE << sel_q;
                    state_q  <= IDLE;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o         = gnt_q;
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign mem_addr_in_o = addr_q;
    assign mem_data_in_o = data_q;
    assign mem_wb_in_o   = wb_q;
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one single-port synchronous memory (32-bit data/address bus, 4-bit byte write-enable, wb=0 means read) between NUM_PORTS requesters, e.g. the core and the network interface DMA.
- Accepts one transaction at a time, selects the winner by round-robin, and drives the memory inputs from registers.
- Waits out the memory read latency, then returns read data to the winning requester with a one-cycle valid pulse.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- MEMORY_BUS_WIDTH, 32, width of data and address buses.
- MEM_LAT, 1, memory read latency in cycles, counted from the edge that samples the address to the cycle in which data_out is valid (1..4).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-port request; held high with stable payload until its gnt bit is seen.
- wb  in  4*NUM_PORTS  per-port byte write-enable, slice [4k+3:4k]; 0 = read.
- addr  in  MEMORY_BUS_WIDTH*NUM_PORTS  per-port address, slice k.
- wdata  in  MEMORY_BUS_WIDTH*NUM_PORTS  per-port write data, slice k.
- gnt  out  NUM_PORTS  one-hot, one-cycle pulse: transaction of port k issued this cycle.
- rvalid  out  NUM_PORTS  one-hot, one-cycle pulse: rdata holds port k's read result.
- rdata  out  MEMORY_BUS_WIDTH  read data, shared by all ports.
- mem_addr_in  out  MEMORY_BUS_WIDTH  to memory addr_in.
- mem_data_in  out  MEMORY_BUS_WIDTH  to memory data_in.
- mem_wb_in  out  4  to memory wb_in.
- mem_data_out  in  MEMORY_BUS_WIDTH  from memory data_out.

Behaviour:
- Reset values:
  - state=IDLE, gnt=0, rvalid=0, rdata=0.
  - mem_addr_in=0, mem_data_in=0, mem_wb_in=0.
  - Round-robin pointer set so port 0 has highest priority; wait counter=0.
- Reset applies on any cycle, including mid-transaction:
  - the in-flight read is dropped and no rvalid is produced;
  - mem_wb_in=0 from the cycle after the reset edge.
- State IDLE:
  - req sampled only in this state.
  - If req!=0 at edge E0: winner k = first set bit at or after the pointer, searching upward with wrap-around.
  - Register addr[k], wdata[k], wb[k] into the mem_* outputs, set gnt=onehot(k), then go to ACCESS.
  - Pointer becomes (k+1) mod NUM_PORTS.
  - If req==0: stay in IDLE.
- State ACCESS (exactly 1 cycle):
  - gnt and mem_* valid; the memory samples them at the closing edge E1.
  - The requester may drop or change req from the cycle after gnt.
  - If wb[k]!=0 (write): next state IDLE, no rvalid. Write throughput is 1 transaction per 2 cycles.
  - If wb[k]==0 (read): next state WAIT, counter=MEM_LAT-1.
- State WAIT:
  - mem_wb_in=0; mem_addr_in is held.
  - Decrement the counter each cycle.
  - In the cycle where counter==0: at the closing edge, rdata<=mem_data_out, rvalid<=onehot(k), state<=IDLE.
- Read timeline with MEM_LAT=1:
  - req sampled at E0, gnt high T1, WAIT T2, rvalid+rdata high T3.
  - A new request can be sampled at E3.
  - Generally rvalid is asserted MEM_LAT+1 cycles after gnt.
- Outside ACCESS: gnt=0 and mem_wb_in=0, so no spurious writes.
- Outside the rvalid cycle: rvalid=0; rdata holds its last value.
- Any non-zero wb is a write; byte lanes pass through unchanged to mem_wb_in. No data alignment or shifting.
- Simultaneous requests: exactly one winner per IDLE cycle. A loser keeps req asserted and is served later. Starvation is impossible because every port wins within NUM_PORTS grants.
- A req bit dropped before its gnt is not an error; an unsampled request is ignored.
- mem_addr_in/mem_data_in width equals MEMORY_BUS_WIDTH; no truncation or extension.

Optional Feature:
- Macro: MEMORY_ARB_FIXED_PRIORITY_EN.
- Defined: lowest-index requesting port always wins; the pointer is not maintained. Port 0 can starve higher ports.
- Undefined (default): round-robin as above.

Test Plan:
- Single read, MEM_LAT=1: port 0 req, wb=0, addr=0x100, memory returns 0xDEADBEEF → gnt[0] at T1, mem_addr_in=0x100, mem_wb_in=0 throughout, rvalid[0] at T3, rdata=0xDEADBEEF.
- Byte write: port 1 wb=4'b0010, addr=0x204, wdata=0x0000AB00 → gnt[1] at T1 with mem_wb_in=4'b0010, mem_data_in=0x0000AB00; mem_wb_in=0 at T2; no rvalid.
- Contention: both ports hold read req continuously for 4 transactions → gnt order 0,1,0,1; each rvalid goes to the matching port with the correct data.
- Latency: MEM_LAT=3 read → rvalid exactly 4 cycles after gnt; next gnt no earlier than 1 cycle after rvalid.
- Reset mid-read: assert reset during WAIT → no rvalid, all outputs 0 next cycle; after reset, both ports request and port 0 wins first.
- With MEMORY_ARB_FIXED_PRIORITY_EN defined, both ports requesting continuously for 3 transactions → gnt[0] three times, gnt[1] never.
